// File: rtl/face_box_overlay.sv
// -----------------------------------------------------------------------------
// face_box_overlay
//
// Consumer side of the face-detection outline mask. The detection core writes
// a 1-bit mask (one bit per pixel address) while this block sits in LOAD.
// mask_done starts a pixel pass: raster pixels stream through with a one-cycle
// registered latency, and every pixel whose mask bit is set is replaced by
// BOX_VAL, which draws the face rectangles. After the last pixel leaves, the
// block zeroes the part of the mask it used (up to the highest written
// address) and returns to LOAD. After reset, the whole mask (DEPTH entries)
// is cleared.
//
// Build option:
//   FACE_OVERLAY_STATS_EN - adds marked_cnt, the number of pixels replaced
//                           with BOX_VAL in the current frame.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   mask_wr_en/addr/data mask write port (honoured in LOAD only)
//   mask_done           one-cycle pulse: mask complete, start the pixel pass
//   frame_len           pixels in the frame, sampled on mask_done
//   in_valid/in_ready/in_pix     input pixel stream
//   out_valid/out_ready/out_pix/out_last  output pixel stream
//   busy                high in every state except LOAD
//   marked_cnt          (stats build only) replaced-pixel count
//
// Handshake: a transfer happens on a rising clk edge where valid && ready are
// both high. A producer holds valid and its data stable until that edge;
// ready may be raised or lowered freely and never waits on valid.
// -----------------------------------------------------------------------------
module face_box_overlay #(
  parameter int PIX_W   = 8,
  parameter int ADDR_W  = 17,
  parameter int DEPTH   = 100000,
  parameter int BOX_VAL = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mask_wr_en,
  input  logic [ADDR_W-1:0] mask_wr_addr,
  input  logic              mask_wr_data,
  input  logic              mask_done,
  input  logic [31:0]       frame_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PIX_W-1:0]  in_pix,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PIX_W-1:0]  out_pix,
  output logic              out_last,
  output logic              busy
`ifdef FACE_OVERLAY_STATS_EN
  ,
  output logic [31:0]       marked_cnt
`endif
);

  localparam int               IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0]      DEPTH32 = 32'(DEPTH);
  localparam logic [PIX_W-1:0] BOX_PIX = PIX_W'(BOX_VAL);

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t             r_state;
  logic [31:0]        r_clr_cnt;
  logic [31:0]        r_clr_lim;
  logic [31:0]        r_hi_water;
  logic [31:0]        r_pix_cnt;
  logic [31:0]        r_len;
  logic               r_out_valid;
  logic [PIX_W-1:0]   r_out_pix;
  logic               r_out_last;
  logic               r_busy;
  logic               r_mask [DEPTH];
`ifdef FACE_OVERLAY_STATS_EN
  logic [31:0]        r_marked_cnt;
`endif

  logic [31:0]        w_wr_addr32;
  logic               w_wr_ok;
  logic [31:0]        w_wr_top;
  logic [31:0]        w_hi_next;
  logic [31:0]        w_len_next;
  logic               w_in_fire;
  logic               w_out_fire;
  logic               w_mask_bit;
  logic               w_pix_last;
  logic               w_clr_last;

  // Out-of-range writes are dropped; the high-water mark only tracks writes
  // that actually landed, so the post-frame clear stays as short as possible.
  assign w_wr_addr32 = 32'(mask_wr_addr);
  assign w_wr_ok     = mask_wr_en && (w_wr_addr32 < DEPTH32);
  assign w_wr_top    = w_wr_addr32 + 32'd1;
  assign w_hi_next   = (w_wr_ok && (w_wr_top > r_hi_water)) ? w_wr_top : r_hi_water;
  assign w_len_next  = (frame_len > DEPTH32) ? DEPTH32 : frame_len;

  // The output register can take a new pixel when it is empty or draining.
  assign in_ready    = (r_state == RUN) && (!r_out_valid || out_ready);
  assign w_in_fire   = in_valid && in_ready;
  assign w_out_fire  = r_out_valid && out_ready;

  // Combinational mask read keeps the pixel path at one register of latency.
  assign w_mask_bit  = r_mask[r_pix_cnt[IDX_W-1:0]];
  assign w_pix_last  = (r_pix_cnt == (r_len - 32'd1));
  assign w_clr_last  = (r_clr_cnt == (r_clr_lim - 32'd1));

  assign out_valid   = r_out_valid;
  assign out_pix     = r_out_pix;
  assign out_last    = r_out_last;
  assign busy        = r_busy;
`ifdef FACE_OVERLAY_STATS_EN
  assign marked_cnt  = r_marked_cnt;
`endif

  // Mask storage has no reset; the CLEAR pass after reset zeroes it.
  always_ff @(posedge clk) begin
    if ((r_state == CLEAR) && (r_clr_lim != 32'd0)) begin
      r_mask[r_clr_cnt[IDX_W-1:0]] <= 1'b0;
    end else if ((r_state == LOAD) && w_wr_ok) begin
      r_mask[mask_wr_addr[IDX_W-1:0]] <= mask_wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= CLEAR;
      r_clr_cnt   <= 32'd0;
      r_clr_lim   <= DEPTH32;
      r_hi_water  <= 32'd0;
      r_pix_cnt   <= 32'd0;
      r_len       <= 32'd0;
      r_out_valid <= 1'b0;
      r_out_pix   <= '0;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b1;
`ifdef FACE_OVERLAY_STATS_EN
      r_marked_cnt <= 32'd0;
`endif
    end else begin
      case (r_state)
        CLEAR: begin
          // A zero-length clear still spends one cycle here.
          if ((r_clr_lim == 32'd0) || w_clr_last) begin
            r_state    <= LOAD;
            r_busy     <= 1'b0;
            r_clr_cnt  <= 32'd0;
            r_hi_water <= 32'd0;
          end else begin
            r_clr_cnt <= r_clr_cnt + 32'd1;
          end
        end

        LOAD: begin
          r_hi_water <= w_hi_next;
          if (mask_done) begin
            r_len     <= w_len_next;
            r_pix_cnt <= 32'd0;
            r_busy    <= 1'b1;
`ifdef FACE_OVERLAY_STATS_EN
            r_marked_cnt <= 32'd0;
`endif
            if (w_len_next == 32'd0) begin
              // Empty frame: skip straight to clearing what was written,
              // including a write landing in this same cycle.
              r_state   <= CLEAR;
              r_clr_lim <= w_hi_next;
              r_clr_cnt <= 32'd0;
            end else begin
              r_state <= RUN;
            end
          end
        end

        RUN: begin
          if (w_in_fire) begin
            r_out_pix   <= w_mask_bit ? BOX_PIX : in_pix;
            r_out_valid <= 1'b1;
            r_out_last  <= w_pix_last;
            r_pix_cnt   <= r_pix_cnt + 32'd1;
`ifdef FACE_OVERLAY_STATS_EN
            if (w_mask_bit) begin
              r_marked_cnt <= r_marked_cnt + 32'd1;
            end
`endif
            if (w_pix_last) begin
              r_state <= DRAIN;
            end
          end else if (w_out_fire) begin
            r_out_valid <= 1'b0;
          end
        end

        DRAIN: begin
          if (w_out_fire) begin
            r_out_valid <= 1'b0;
            r_state     <= CLEAR;
            r_clr_lim   <= r_hi_water;
            r_clr_cnt   <= 32'd0;
          end
        end

        default: begin
          r_state <= CLEAR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_face_box_overlay.sv
// -----------------------------------------------------------------------------
// tb_face_box_overlay
//
// Bench for face_box_overlay with a 64-entry mask. The main thread drives the
// mask port and input pixels just after each falling edge and pushes the
// hand-computed expected pixel/last pair into exp_q. A monitor, also on the
// falling edge, pops and compares whenever an output transfer is pending, and
// checks that a stalled output holds still. out_ready follows a small pattern
// driven just after each rising edge.
// -----------------------------------------------------------------------------
module tb_face_box_overlay;

  localparam int PIX_W  = 8;
  localparam int ADDR_W = 17;
  localparam int DEPTH  = 64;
  localparam int W      = PIX_W + 1;

  logic              clk;
  logic              reset;
  logic              mask_wr_en;
  logic [ADDR_W-1:0] mask_wr_addr;
  logic              mask_wr_data;
  logic              mask_done;
  logic [31:0]       frame_len;
  logic              in_valid;
  logic              in_ready;
  logic [PIX_W-1:0]  in_pix;
  logic              out_valid;
  logic              out_ready;
  logic [PIX_W-1:0]  out_pix;
  logic              out_last;
  logic              busy;
`ifdef FACE_OVERLAY_STATS_EN
  logic [31:0]       marked_cnt;
`endif

  logic [W-1:0] exp_q[$];
  int           exp_cyc_q[$];
  int           total = 0;
  int           bad   = 0;
  int           cyc   = 0;
  int           rdy_pat[4] = '{1, 1, 1, 1};
  int           rdy_k = 0;

  logic             held;
  logic [PIX_W-1:0] held_pix;
  logic             held_last;
  logic [W-1:0]     mon_e;
  int               mon_c;

  face_box_overlay #(
    .PIX_W  (PIX_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .BOX_VAL(255)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .mask_wr_en  (mask_wr_en),
    .mask_wr_addr(mask_wr_addr),
    .mask_wr_data(mask_wr_data),
    .mask_done   (mask_done),
    .frame_len   (frame_len),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_pix      (in_pix),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pix     (out_pix),
    .out_last    (out_last),
    .busy        (busy)
`ifdef FACE_OVERLAY_STATS_EN
    ,
    .marked_cnt  (marked_cnt)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, bench did not finish");
    $fatal(1, "watchdog");
  end

  // out_ready pattern driver
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = (rdy_pat[rdy_k % 4] != 0);
      rdy_k = rdy_k + 1;
    end
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    held = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        held = 1'b0;
      end else begin
        if (held) begin
          check("stall_valid", 64'(out_valid), 64'd1);
          check("stall_pix", 64'(out_pix), 64'(held_pix));
          check("stall_last", 64'(out_last), 64'(held_last));
        end
        held      = out_valid && !out_ready;
        held_pix  = out_pix;
        held_last = out_last;
        if (out_valid && !out_ready) begin
          check("stall_in_ready", 64'(in_ready), 64'd0);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            total = total + 1;
            bad   = bad + 1;
            $display("FAIL unexpected_out: got pix %0d with no expected pixel pending", out_pix);
          end else begin
            mon_e = exp_q.pop_front();
            mon_c = exp_cyc_q.pop_front();
            check("out_pix", 64'(out_pix), 64'(mon_e[PIX_W-1:0]));
            check("out_last", 64'(out_last), 64'(mon_e[PIX_W]));
            if (mon_c >= 0) check("latency_cycle", 64'(cyc), 64'(mon_c));
          end
        end
      end
    end
  end

  // ---------------- driver tasks (enter and leave just after a falling edge) ----------------
  task automatic mask_wr(input int addr);
    mask_wr_en   = 1'b1;
    mask_wr_addr = ADDR_W'(addr);
    mask_wr_data = 1'b1;
    @(negedge clk);
    mask_wr_en   = 1'b0;
  endtask

  task automatic mask_done_pulse(input int len, input logic wr, input int addr);
    mask_done    = 1'b1;
    frame_len    = 32'(len);
    mask_wr_en   = wr;
    mask_wr_addr = ADDR_W'(addr);
    mask_wr_data = 1'b1;
    @(negedge clk);
    mask_done    = 1'b0;
    mask_wr_en   = 1'b0;
  endtask

  task automatic send_pix(input int p, input int e, input logic last, input logic chk_lat);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_pix   = PIX_W'(p);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n = n + 1;
    end
    if (!in_ready) begin
      total = total + 1;
      bad   = bad + 1;
      $display("FAIL in_ready_timeout: got in_ready=0 required 1 within 50 cycles");
    end else begin
      exp_q.push_back({last, PIX_W'(e)});
      exp_cyc_q.push_back(chk_lat ? cyc + 1 : -1);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 500) begin
      @(negedge clk);
      n = n + 1;
    end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int n;
    reset        = 1'b1;
    mask_wr_en   = 1'b0;
    mask_wr_addr = '0;
    mask_wr_data = 1'b0;
    mask_done    = 1'b0;
    frame_len    = 32'd0;
    in_valid     = 1'b0;
    in_pix       = '0;
    repeat (3) @(negedge clk);

    // reset values
    check("rst_busy", 64'(busy), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_pix", 64'(out_pix), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    reset = 1'b0;
    wait_idle(n);
    check("rst_clear_cycles", 64'(n), 64'd64);

    // frame 1: empty mask, ramp 0..15
    mask_done_pulse(16, 1'b0, 0);
    for (int i = 0; i < 16; i++) send_pix(i, i, (i == 15), 1'b1);
    wait_idle(n);

    // frame 2: mask 3..5, full throughput
    mask_wr(3); mask_wr(4); mask_wr(5);
    mask_done_pulse(8, 1'b0, 0);
    for (int i = 0; i < 8; i++) send_pix(100, (i >= 3 && i <= 5) ? 255 : 100, (i == 7), 1'b1);
    wait_idle(n);
`ifdef FACE_OVERLAY_STATS_EN
    check("marked_cnt", 64'(marked_cnt), 64'd3);
`endif

    // frame 3: same mask, out_ready toggling 1,0,0,1
    rdy_pat = '{1, 0, 0, 1};
    mask_wr(3); mask_wr(4); mask_wr(5);
    mask_done_pulse(8, 1'b0, 0);
    for (int i = 0; i < 8; i++) send_pix(100, (i >= 3 && i <= 5) ? 255 : 100, (i == 7), 1'b0);
    wait_idle(n);
    rdy_pat = '{1, 1, 1, 1};
    check("stall_frame_drained", 64'(exp_q.size()), 64'd0);

    // frame 4: out-of-range write dropped, write alongside mask_done kept
    mask_wr(70);
    mask_done_pulse(4, 1'b1, 2);
    for (int i = 0; i < 4; i++) send_pix(10, (i == 2) ? 255 : 10, (i == 3), 1'b1);
    wait_idle(n);
    check("hi_water_clear_cycles", 64'(n), 64'd4);
    mask_done_pulse(4, 1'b0, 0);
    for (int i = 0; i < 4; i++) send_pix(10, 10, (i == 3), 1'b1);
    wait_idle(n);

    // frame 5: zero-length frame goes straight to clearing
    mask_wr(7);
    mask_done_pulse(0, 1'b0, 0);
    n = 0;
    while (busy && n < 500) begin
      check("len0_in_ready", 64'(in_ready), 64'd0);
      check("len0_out_valid", 64'(out_valid), 64'd0);
      @(negedge clk);
      n = n + 1;
    end
    check("len0_clear_cycles", 64'(n), 64'd8);
    mask_done_pulse(8, 1'b0, 0);
    for (int i = 0; i < 8; i++) send_pix(7, 7, (i == 7), 1'b1);
    wait_idle(n);

    // frame 6: reset mid-frame after 4 pixels
    mask_wr(1); mask_wr(2);
    mask_done_pulse(8, 1'b0, 0);
    for (int i = 0; i < 4; i++) send_pix(40, (i == 1 || i == 2) ? 255 : 40, 1'b0, 1'b1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd0);
    check("midrst_busy", 64'(busy), 64'd1);
    check("midrst_out_last", 64'(out_last), 64'd0);
    exp_q.delete();
    exp_cyc_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wait_idle(n);
    check("midrst_clear_cycles", 64'(n), 64'd64);
    mask_done_pulse(8, 1'b0, 0);
    for (int i = 0; i < 8; i++) send_pix(40, 40, (i == 7), 1'b1);
    wait_idle(n);

    repeat (3) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
